pcie_link_led: RTL and testbench
================================

PCIE_LINK_LED -- requirements
Module: pcie_link_led

Interface
REQ-001 SHALL have parameter HB_HALF, default 125000000, meaning clk cycles per heartbeat half-period (>=2).
REQ-002 SHALL have parameter DEB_CYC, default 1024, meaning consecutive synced link-up cycles required before UP (>=2).
REQ-003 SHALL have parameter LOST_CYC, default 250000000, meaning clk cycles spent in LOST before returning to DOWN (>=1).
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, meaning the asynchronous active-high reset.
REQ-006 SHALL have port pcie_link_up, input, 1, meaning the link-up status from the PCIe subsystem, asynchronous to clk.
REQ-007 SHALL have port pcie_perst_n, input, 1, meaning the board PERST#, active-low and asynchronous to clk.
REQ-008 SHALL have port clr_sticky, input, 1, meaning a synchronous one-cycle pulse that clears led[3] and led[7:4].
REQ-009 SHALL have port led, output, 8, meaning the registered board LED vector.

Function
REQ-010 SHALL pass pcie_link_up and pcie_perst_n each through a 2-FF synchronizer; all further logic uses only the synced versions (lu_s, perst_s), adding 2 cycles of latency.
REQ-011 SHALL implement FSM states DOWN, TRAIN, UP and LOST.
REQ-012 SHALL move DOWN->TRAIN when lu_s=1 and perst_s=1.
REQ-013 SHALL, in TRAIN, count consecutive lu_s=1 cycles and move to UP when the count reaches DEB_CYC; any lu_s=0 or perst_s=0 returns to DOWN with the count cleared.
REQ-014 SHALL move UP->LOST when lu_s=0 or perst_s=0, and increment the drop counter in that same cycle.
REQ-015 SHALL hold LOST for exactly LOST_CYC cycles, then move to DOWN; lu_s returning during LOST is ignored.
REQ-016 SHALL saturate the 4-bit drop counter at 15 with no wrap-around.
REQ-017 SHALL set the sticky lost flag on UP->LOST and keep it set until clr_sticky or rst.
REQ-018 SHALL, when clr_sticky coincides with UP->LOST, apply the clear and leave flag=1 and count=1.
REQ-019 SHALL drive the LED mapping led[0]=heartbeat, led[1]=(state==UP), led[2]=~perst_s, led[3]=sticky flag, led[7:4]=drop count.
REQ-020 SHALL register every led bit, so each bit updates one cycle after its source state or counter changes.
REQ-021 SHALL toggle the heartbeat every HB_HALF cycles, free-running and independent of the FSM.

Reset
REQ-022 SHALL, on rst=1, asynchronously clear the synchronizers, FSM (to DOWN), all counters, sticky flag and led to 8'h00.
REQ-023 SHALL restart cleanly in DOWN after rst deasserts mid-TRAIN/UP/LOST, with no drop counted for the interrupted state.

Configuration
REQ-024 SHALL, with PCIE_LINK_LED_HB_EN defined, instantiate the heartbeat divider as described in REQ-021.
REQ-025 SHALL, without PCIE_LINK_LED_HB_EN, omit the divider entirely and tie led[0] to 0; all other behaviour is unchanged.

Structure
REQ-026 SHALL place the state enum type (link_st_t) and the LED bit-index constants (LED_HB, LED_UP, LED_PERST, LED_LOST, LED_CNT_LSB) in shared package pcie_led_pkg.
REQ-027 SHALL implement both synchronizers by instantiating the single sub-module sync_2ff, with no other sub-modules.

Verification (HB_HALF=4, DEB_CYC=8, LOST_CYC=5)
REQ-028 SHALL check: link_up held 1 with perst_n=1 -> led[1] rises exactly 2+8+1 cycles after the edge (±1 for sync).
REQ-029 SHALL check: link_up glitch of 3 cycles in TRAIN -> state returns to DOWN, led[1] stays 0, drop count 0.
REQ-030 SHALL check: drop from UP -> led[3]=1, led[7:4]=1; link_up re-asserted during LOST is ignored and DOWN is entered after 5 cycles.
REQ-031 SHALL check: 17 full up/down cycles -> led[7:4]=4'hF (saturated); a clr_sticky pulse -> led[7:3]=0.
REQ-032 SHALL check: rst pulse asserted mid-UP -> led=8'h00 asynchronously, before any clk edge.
REQ-033 SHALL check: heartbeat period is 8 cycles with PCIE_LINK_LED_HB_EN defined and led[0] is constant 0 without it.

Source files
------------

// File: rtl/pcie_led_pkg.sv
// Shared types and LED bit positions for the PCIe link status LED block.
package pcie_led_pkg;

    typedef enum logic [1:0] {
        ST_DOWN  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_UP    = 2'd2,
        ST_LOST  = 2'd3
    } link_st_t;

    localparam int LED_HB      = 0;
    localparam int LED_UP      = 1;
    localparam int LED_PERST   = 2;
    localparam int LED_LOST    = 3;
    localparam int LED_CNT_LSB = 4;

    localparam int         DROP_W   = 4;
    localparam logic [3:0] DROP_MAX = 4'hF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Capture stage followed by resolve stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pcie_link_led.sv
// PCIe link status LED driver: debounced link FSM, drop counter, sticky flag.
// Heartbeat divider on led[0] is built only when PCIE_LINK_LED_HB_EN is defined.
module pcie_link_led
    import pcie_led_pkg::*;
#(
    parameter int HB_HALF  = 125000000,
    parameter int DEB_CYC  = 1024,
    parameter int LOST_CYC = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pcie_link_up,
    input  logic       pcie_perst_n,
    input  logic       clr_sticky,
    output logic [7:0] led
);

    localparam int DC_W = $clog2(DEB_CYC);
    localparam int LC_W = (LOST_CYC > 1) ? $clog2(LOST_CYC) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYC - 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOST_CYC - 1);

    logic              lu_s;
    logic              perst_s;
    logic              link_ok_s;
    link_st_t          state_r;
    link_st_t          state_nxt_s;
    logic [DC_W-1:0]   deb_cnt_r;
    logic [DC_W-1:0]   deb_cnt_nxt_s;
    logic [LC_W-1:0]   lost_cnt_r;
    logic [LC_W-1:0]   lost_cnt_nxt_s;
    logic              drop_ev_s;
    logic [DROP_W-1:0] drop_cnt_r;
    logic              sticky_r;
    logic              hb_s;
    logic [7:0]        led_r;

    sync_2ff u_sync_lu (
        .clk (clk),
        .rst (rst),
        .d   (pcie_link_up),
        .q   (lu_s)
    );

    sync_2ff u_sync_perst (
        .clk (clk),
        .rst (rst),
        .d   (pcie_perst_n),
        .q   (perst_s)
    );

    assign link_ok_s = lu_s & perst_s;

    // Link FSM next-state; the DOWN->TRAIN cycle counts as the first good sample.
    always_comb begin
        state_nxt_s    = state_r;
        deb_cnt_nxt_s  = deb_cnt_r;
        lost_cnt_nxt_s = lost_cnt_r;
        drop_ev_s      = 1'b0;
        case (state_r)
            ST_DOWN: begin
                if (link_ok_s) begin
                    state_nxt_s   = ST_TRAIN;
                    deb_cnt_nxt_s = DC_W'(1'b1);
                end else begin
                    deb_cnt_nxt_s = {DC_W{1'b0}};
                end
            end
            ST_TRAIN: begin
                if (!link_ok_s) begin
                    state_nxt_s   = ST_DOWN;
                    deb_cnt_nxt_s = {DC_W{1'b0}};
                end else if (deb_cnt_r == DC_LAST) begin
                    state_nxt_s   = ST_UP;
                    deb_cnt_nxt_s = {DC_W{1'b0}};
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DC_W'(1'b1);
                end
            end
            ST_UP: begin
                if (!link_ok_s) begin
                    state_nxt_s    = ST_LOST;
                    lost_cnt_nxt_s = {LC_W{1'b0}};
                    drop_ev_s      = 1'b1;
                end else begin
                    lost_cnt_nxt_s = {LC_W{1'b0}};
                end
            end
            ST_LOST: begin
                if (lost_cnt_r == LC_LAST) begin
                    state_nxt_s    = ST_DOWN;
                    lost_cnt_nxt_s = {LC_W{1'b0}};
                end else begin
                    lost_cnt_nxt_s = lost_cnt_r + LC_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s    = ST_DOWN;
                deb_cnt_nxt_s  = {DC_W{1'b0}};
                lost_cnt_nxt_s = {LC_W{1'b0}};
            end
        endcase
    end

    // FSM state and its counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_DOWN;
            deb_cnt_r  <= {DC_W{1'b0}};
            lost_cnt_r <= {LC_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            deb_cnt_r  <= deb_cnt_nxt_s;
            lost_cnt_r <= lost_cnt_nxt_s;
        end
    end

    // Sticky flag and saturating drop count; a drop in the clear cycle survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r   <= 1'b0;
            drop_cnt_r <= 4'h0;
        end else if (clr_sticky) begin
            sticky_r   <= drop_ev_s;
            drop_cnt_r <= drop_ev_s ? 4'h1 : 4'h0;
        end else if (drop_ev_s) begin
            sticky_r <= 1'b1;
            if (drop_cnt_r != DROP_MAX) begin
                drop_cnt_r <= drop_cnt_r + 4'h1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else begin
            sticky_r   <= sticky_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

`ifdef PCIE_LINK_LED_HB_EN
    localparam int HB_W = $clog2(HB_HALF);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF - 1);

    logic [HB_W-1:0] hb_cnt_r;
    logic            hb_r;

    // Free-running heartbeat divider, toggles every HB_HALF cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt_r <= {HB_W{1'b0}};
            hb_r     <= 1'b0;
        end else if (hb_cnt_r == HB_LAST) begin
            hb_cnt_r <= {HB_W{1'b0}};
            hb_r     <= ~hb_r;
        end else begin
            hb_cnt_r <= hb_cnt_r + HB_W'(1'b1);
        end
    end

    assign hb_s = hb_r;
`else
    assign hb_s = 1'b0;

    // HB_HALF stays on the interface even when the divider is compiled out.
    if (HB_HALF < 2) begin : g_hb_half_range
    end
`endif

    // Registered LED vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= 8'h00;
        end else begin
            led_r[LED_HB]                  <= hb_s;
            led_r[LED_UP]                  <= (state_r == ST_UP);
            led_r[LED_PERST]               <= ~perst_s;
            led_r[LED_LOST]                <= sticky_r;
            led_r[LED_CNT_LSB +: DROP_W]   <= drop_cnt_r;
        end
    end

    assign led = led_r;

endmodule

// File: tb/tb_pcie_link_led.sv
// Scoreboard bench for pcie_link_led with HB_HALF=4, DEB_CYC=8, LOST_CYC=5.
// Heartbeat checks follow PCIE_LINK_LED_HB_EN.
module tb_pcie_link_led;

    logic       clk = 1'b0;
    logic       rst;
    logic       pcie_link_up;
    logic       pcie_perst_n;
    logic       clr_sticky;
    logic [7:0] led;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    pcie_link_led #(
        .HB_HALF  (4),
        .DEB_CYC  (8),
        .LOST_CYC (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcie_link_up (pcie_link_up),
        .pcie_perst_n (pcie_perst_n),
        .clr_sticky   (clr_sticky),
        .led          (led)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    // Counts posedges until led[idx]==val; n=-1 if max_cyc expires.
    task automatic wait_led(input int idx, input logic val, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (led[idx] == val) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ones;
        int fall;
        int rise;
        int tmo;
        int h;
        int l;
        logic [7:0] led_at_fall;

        rst          = 1'b1;
        pcie_link_up = 1'b0;
        pcie_perst_n = 1'b0;
        clr_sticky   = 1'b0;

        sb_push("reset_led", 32'h00);
        repeat (3) @(negedge clk);
        sb_pop({24'h0, led});

        // PERST# still asserted after reset release
        sb_push("perst_low", 32'h04);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        sb_pop({24'h0, led & 8'hFE});

        sb_push("idle", 32'h00);
        pcie_perst_n = 1'b1;
        repeat (4) @(negedge clk);
        sb_pop({24'h0, led & 8'hFE});

        // 3-cycle link_up glitch must not reach UP
        sb_push("glitch_up_cycles", 32'd0);
        sb_push("glitch_sticky_cnt", 32'h00);
        pcie_link_up = 1'b1;
        repeat (3) @(negedge clk);
        pcie_link_up = 1'b0;
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ones += int'(led[1]);
        end
        sb_pop(ones);
        sb_pop({24'h0, led & 8'hF8});

        // Clean bring-up latency: 2 sync + 8 debounce + 1 led register
        sb_push("bringup_latency", 32'd11);
        sb_push("bringup_led", 32'h02);
        pcie_link_up = 1'b1;
        wait_led(1, 1'b1, 40, n);
        sb_pop(n);
        sb_pop({24'h0, led & 8'hFE});

        // Drop from UP, link_up returns during LOST
        sb_push("drop_fall_latency", 32'd4);
        sb_push("drop_led", 32'h18);
        sb_push("lost_reup_latency", 32'd17);
        @(negedge clk);
        pcie_link_up = 1'b0;
        fall = -1;
        rise = -1;
        led_at_fall = 8'hFF;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) pcie_link_up = 1'b1;
            if (fall < 0 && !led[1]) begin
                fall = i;
                led_at_fall = led & 8'hFE;
            end else if (fall >= 0 && led[1]) begin
                rise = i;
                break;
            end
        end
        sb_pop(fall);
        sb_pop({24'h0, led_at_fall});
        sb_pop(rise);

        // clr_sticky in the same cycle as UP->LOST
        sb_push("clr_coincide", 32'h18);
        @(negedge clk);
        pcie_link_up = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        repeat (3) @(negedge clk);
        sb_pop({24'h0, led & 8'hFE});
        repeat (10) @(negedge clk);

        // 15 more drops (17 total), alternating link_up and PERST# drops
        sb_push("sat_timeouts", 32'd0);
        sb_push("sat_led", 32'hF8);
        tmo = 0;
        for (int k = 0; k < 15; k++) begin
            pcie_link_up = 1'b1;
            wait_led(1, 1'b1, 40, n);
            if (n < 0) tmo++;
            @(negedge clk);
            if (k % 2 == 1) pcie_perst_n = 1'b0;
            else            pcie_link_up = 1'b0;
            wait_led(1, 1'b0, 20, n);
            if (n < 0) tmo++;
            repeat (8) @(negedge clk);
            pcie_perst_n = 1'b1;
            pcie_link_up = 1'b0;
            repeat (4) @(negedge clk);
        end
        sb_pop(tmo);
        sb_pop({24'h0, led & 8'hF8});

        sb_push("clr_sticky", 32'h00);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        @(negedge clk);
        sb_pop({24'h0, led & 8'hF8});

        // Asynchronous reset while UP
        sb_push("upcheck_before_rst", 32'h02);
        sb_push("async_rst", 32'h00);
        sb_push("restart_latency", 32'd11);
        sb_push("restart_led", 32'h02);
        pcie_link_up = 1'b1;
        wait_led(1, 1'b1, 40, n);
        @(negedge clk);
        sb_pop({24'h0, led & 8'hFE});
        #2 rst = 1'b1;
        #1 sb_pop({24'h0, led});
        @(negedge clk);
        rst = 1'b0;
        wait_led(1, 1'b1, 40, n);
        sb_pop(n);
        sb_pop({24'h0, led & 8'hFE});

`ifdef PCIE_LINK_LED_HB_EN
        sb_push("hb_period", 32'd8);
        sb_push("hb_high", 32'd4);
        wait_led(0, 1'b1, 20, n);
        wait_led(0, 1'b0, 20, h);
        wait_led(0, 1'b1, 20, l);
        sb_pop(h + l);
        sb_pop(h);
`else
        sb_push("hb_tied_low", 32'd0);
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ones += int'(led[0]);
        end
        sb_pop(ones);
`endif

        check_val("sb_leftover", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
